// File: rtl/sample_adapt_pkg.sv
// Shared definitions for the sample width adapter: alignment modes,
// supported width limits and the internal wide-datapath width helper.
package sample_adapt_pkg;

  // How an input sample is mapped onto the output word.
  typedef enum logic [0:0] {
    ALIGN_VALUE = 1'b0,  // keep numeric value (sign-extend or saturate)
    ALIGN_MSB   = 1'b1   // keep MSB position (scale by 2^(OUT_W-IN_W))
  } align_e;

  localparam int SAMPLE_W_MIN = 2;
  localparam int SAMPLE_W_MAX = 32;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 8;

  // One guard bit above the wider of the two sample widths holds every
  // intermediate value (left shift result or rounded narrowing result).
  function automatic int wide_width(input int in_w, input int out_w);
    return ((in_w > out_w) ? in_w : out_w) + 1;
  endfunction

endpackage

// File: rtl/sample_convert.sv
// Per-lane sample conversion: combinational shift/round into the wide
// domain (stage-1 input) and saturation back to OUT_W (stage-2 input).
// SAMPLE_ADAPT_ROUND_EN: when defined, MSB-aligned narrowing rounds half up
// instead of truncating toward negative infinity.
module sample_convert
  import sample_adapt_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16,
  parameter int ALIGN = 0
) (
  input  logic [IN_W-1:0]                        sample_i,
  output logic [wide_width(IN_W, OUT_W)-1:0]     wide_o,
  input  logic [wide_width(IN_W, OUT_W)-1:0]     wide_i,
  output logic [OUT_W-1:0]                       sat_o,
  output logic                                   clip_o
);

  localparam int     WIDE_W = wide_width(IN_W, OUT_W);
  localparam align_e MODE   = (ALIGN != 0) ? ALIGN_MSB : ALIGN_VALUE;
  localparam int     SHL    = (OUT_W > IN_W) ? (OUT_W - IN_W) : 0;
  localparam int     SHR    = (IN_W > OUT_W) ? (IN_W - OUT_W) : 0;
  localparam int     RND_SH = (SHR > 0) ? (SHR - 1) : 0;

`ifdef SAMPLE_ADAPT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam logic signed [WIDE_W-1:0] ONE_W     = {{(WIDE_W-1){1'b0}}, 1'b1};
  localparam logic signed [WIDE_W-1:0] ROUND_ADD =
    (ROUND_EN && (SHR > 0)) ? (ONE_W << RND_SH) : {WIDE_W{1'b0}};
  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN =
    {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [WIDE_W-1:0] ext_s;
  logic signed [WIDE_W-1:0] wide_s;
  logic signed [WIDE_W-1:0] wide_in_s;

  assign ext_s     = {{(WIDE_W-IN_W){sample_i[IN_W-1]}}, sample_i};
  assign wide_in_s = wide_i;
  assign wide_o    = wide_s;

  // Place the sample on the output scale; narrowing keeps one guard bit so
  // the rounding add cannot overflow.
  always_comb begin
    wide_s = ext_s;
    if (MODE == ALIGN_MSB) begin
      if (SHR > 0) begin
        wide_s = (ext_s + ROUND_ADD) >>> SHR;
      end else begin
        wide_s = ext_s <<< SHL;
      end
    end else begin
      wide_s = ext_s;
    end
  end

  // Clamp the wide value into the signed OUT_W range and report clipping.
  always_comb begin
    sat_o  = wide_in_s[OUT_W-1:0];
    clip_o = 1'b0;
    if (wide_in_s > SAT_MAX) begin
      sat_o  = SAT_MAX[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (wide_in_s < SAT_MIN) begin
      sat_o  = SAT_MIN[OUT_W-1:0];
      clip_o = 1'b1;
    end else begin
      sat_o  = wide_in_s[OUT_W-1:0];
      clip_o = 1'b0;
    end
  end

endmodule

// File: rtl/sample_width_adapter.sv
// Multi-lane signed sample width adapter: two-stage valid/ready pipeline
// (stage 1 = wide shifted value, stage 2 = saturated result) with sticky
// per-lane clip flags and a saturating clipped-beat counter.
// SAMPLE_ADAPT_ROUND_EN: selects round-half-up for MSB-aligned narrowing.
module sample_width_adapter
  import sample_adapt_pkg::*;
#(
  parameter int IN_W     = 12,
  parameter int OUT_W    = 16,
  parameter int CHANNELS = 2,
  parameter int ALIGN    = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [CHANNELS-1:0]       clip_flag,
  input  logic                      clip_clear,
  output logic [CNT_W-1:0]          clip_count
);

  localparam int               WIDE_W  = wide_width(IN_W, OUT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                         s1_valid_q, s1_valid_d;
  logic [CHANNELS*WIDE_W-1:0]   s1_wide_q, s1_wide_d, wide_s;
  logic                         out_valid_q, out_valid_d;
  logic [CHANNELS*OUT_W-1:0]    out_data_q, out_data_d, sat_s;
  logic [CHANNELS-1:0]          clip_flag_q, clip_flag_d, clip_s;
  logic [CNT_W-1:0]             clip_count_q, clip_count_d;
  logic                         s2_ready_s, s2_load_s, s1_ready_s, s1_load_s;
  logic                         clip_event_s;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    sample_convert #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .ALIGN (ALIGN)
    ) u_convert (
      .sample_i (in_data[g*IN_W +: IN_W]),
      .wide_o   (wide_s[g*WIDE_W +: WIDE_W]),
      .wide_i   (s1_wide_q[g*WIDE_W +: WIDE_W]),
      .sat_o    (sat_s[g*OUT_W +: OUT_W]),
      .clip_o   (clip_s[g])
    );
  end

  // Stage 2 frees up when its beat leaves; stage 1 when it can move forward.
  // Together this gives in_ready = out_ready | ~(stage-2 valid & stage-1 valid).
  assign s2_ready_s   = out_ready | ~out_valid_q;
  assign s2_load_s    = s1_valid_q & s2_ready_s;
  assign s1_ready_s   = s2_ready_s | ~s1_valid_q;
  assign s1_load_s    = in_valid & s1_ready_s;
  assign clip_event_s = s2_load_s & (|clip_s);

  assign in_ready   = s1_ready_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign clip_flag  = clip_flag_q;
  assign clip_count = clip_count_q;

  // Next-state for both pipeline stages; data only moves on a real transfer
  // so a stalled output word stays stable.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_wide_d   = s1_wide_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s1_ready_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s1_load_s) begin
      s1_wide_d = wide_s;
    end else begin
      s1_wide_d = s1_wide_q;
    end
    if (s2_ready_s) begin
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (s2_load_s) begin
      out_data_d = sat_s;
    end else begin
      out_data_d = out_data_q;
    end
  end

  // Clip bookkeeping: a clear coinciding with a clip event keeps that event.
  always_comb begin
    clip_flag_d  = clip_flag_q;
    clip_count_d = clip_count_q;
    if (clip_clear) begin
      clip_flag_d  = clip_s & {CHANNELS{s2_load_s}};
      clip_count_d = clip_event_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (clip_event_s) begin
      clip_flag_d  = clip_flag_q | clip_s;
      clip_count_d = (clip_count_q == CNT_MAX) ? clip_count_q : (clip_count_q + CNT_ONE);
    end else begin
      clip_flag_d  = clip_flag_q;
      clip_count_d = clip_count_q;
    end
  end

  // Pipeline and clip state registers; reset discards all in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_wide_q    <= {(CHANNELS*WIDE_W){1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {(CHANNELS*OUT_W){1'b0}};
      clip_flag_q  <= {CHANNELS{1'b0}};
      clip_count_q <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_wide_q    <= s1_wide_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      clip_flag_q  <= clip_flag_d;
      clip_count_q <= clip_count_d;
    end
  end

endmodule

// File: tb/tb_sample_width_adapter.sv
// Bench for sample_width_adapter: four configurations (12->16 and 16->12,
// value and MSB alignment) share one handshake and stimulus stream; each is
// compared every cycle against a queue-based arithmetic reference model.
`timescale 1ns/1ps
module tb_sample_width_adapter;

  localparam int NI = 4;

`ifdef SAMPLE_ADAPT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, clip_clear;
  logic [31:0] src0, src1;

  logic [NI-1:0]       dv, dr;
  logic [NI-1:0][63:0] dd;
  logic [NI-1:0][1:0]  dflag;
  logic [NI-1:0][15:0] dcnt;
  logic [31:0] oa, ob;
  logic [23:0] oc, od;
  logic [2:0]  cc, cd;

  assign dd[0] = {32'd0, oa};
  assign dd[1] = {32'd0, ob};
  assign dd[2] = {40'd0, oc};
  assign dd[3] = {40'd0, od};
  assign dcnt[2] = {13'd0, cc};
  assign dcnt[3] = {13'd0, cd};

  sample_width_adapter #(.IN_W(12), .OUT_W(16), .CHANNELS(2), .ALIGN(0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(dr[0]),
    .in_data({src1[11:0], src0[11:0]}), .out_valid(dv[0]), .out_ready(out_ready),
    .out_data(oa), .clip_flag(dflag[0]), .clip_clear(clip_clear), .clip_count(dcnt[0]));
  sample_width_adapter #(.IN_W(12), .OUT_W(16), .CHANNELS(2), .ALIGN(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(dr[1]),
    .in_data({src1[11:0], src0[11:0]}), .out_valid(dv[1]), .out_ready(out_ready),
    .out_data(ob), .clip_flag(dflag[1]), .clip_clear(clip_clear), .clip_count(dcnt[1]));
  sample_width_adapter #(.IN_W(16), .OUT_W(12), .CHANNELS(2), .ALIGN(0), .CNT_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(dr[2]),
    .in_data({src1[15:0], src0[15:0]}), .out_valid(dv[2]), .out_ready(out_ready),
    .out_data(oc), .clip_flag(dflag[2]), .clip_clear(clip_clear), .clip_count(cc));
  sample_width_adapter #(.IN_W(16), .OUT_W(12), .CHANNELS(2), .ALIGN(1), .CNT_W(3)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(dr[3]),
    .in_data({src1[15:0], src0[15:0]}), .out_valid(dv[3]), .out_ready(out_ready),
    .out_data(od), .clip_flag(dflag[3]), .clip_clear(clip_clear), .clip_count(cd));

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] data;
    logic [1:0]  clip;
    int          acc;
  } beat_t;

  beat_t       mq [NI][$];
  bit          shown [NI];
  logic [1:0]  mflag [NI];
  longint      mcnt [NI];
  int          edge_cnt = 0;
  int          n_acc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int iw_of(input int i);   return (i < 2) ? 12 : 16; endfunction
  function automatic int ow_of(input int i);   return (i < 2) ? 16 : 12; endfunction
  function automatic int al_of(input int i);   return i % 2; endfunction
  function automatic longint cmax_of(input int i); return (i < 2) ? 64'sd65535 : 64'sd7; endfunction

  function automatic longint sext(input logic [31:0] x, input int w);
    longint t;
    t = longint'(x) & ((64'sd1 <<< w) - 64'sd1);
    if (t >= (64'sd1 <<< (w - 1))) t = t - (64'sd1 <<< w);
    return t;
  endfunction

  // Numeric meaning of the conversion: scale, optional rounding, floor, clamp.
  function automatic longint conv(input longint v, input int iw, input int ow, input int al,
                                  output bit clip);
    longint r, hi, lo;
    int k;
    if (al == 0) begin
      r = v;
    end else if (ow >= iw) begin
      r = v * (64'sd1 <<< (ow - iw));
    end else begin
      k = iw - ow;
      r = v + (RND ? (64'sd1 <<< (k - 1)) : 64'sd0);
      r = r >>> k;
    end
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    clip = 1'b0;
    if (r > hi) begin r = hi; clip = 1'b1; end
    else if (r < lo) begin r = lo; clip = 1'b1; end
    return r;
  endfunction

  function automatic beat_t make_beat(input int i, input logic [31:0] s0, input logic [31:0] s1,
                                      input int acc);
    beat_t b;
    longint r, mask;
    bit c;
    b.data = 64'd0;
    b.clip = 2'b00;
    b.acc  = acc;
    mask = (64'sd1 <<< ow_of(i)) - 64'sd1;
    for (int l = 0; l < 2; l++) begin
      r = conv(sext((l == 0) ? s0 : s1, iw_of(i)), iw_of(i), ow_of(i), al_of(i), c);
      b.data = b.data | (64'(r & mask) << (l * ow_of(i)));
      b.clip[l] = c;
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      shown[i] = 1'b0;
      mflag[i] = 2'b00;
      mcnt[i]  = 64'sd0;
    end
    edge_cnt = 0;
  endtask

  // A beat becomes visible the cycle after it is both oldest and at least one
  // edge past acceptance; the pipeline holds at most two beats.
  task automatic model_edge();
    bit vis, rdy, entering;
    logic [1:0] ev;
    for (int i = 0; i < NI; i++) begin
      vis = (mq[i].size() > 0) && (mq[i][0].acc + 1 < edge_cnt);
      rdy = out_ready || (mq[i].size() < 2);
      if (vis && out_ready) begin
        void'(mq[i].pop_front());
        shown[i] = 1'b0;
      end
      if (in_valid && rdy) begin
        mq[i].push_back(make_beat(i, src0, src1, edge_cnt));
        if (i == 0) n_acc++;
      end
    end
    edge_cnt++;
    for (int i = 0; i < NI; i++) begin
      entering = (mq[i].size() > 0) && (mq[i][0].acc + 1 < edge_cnt) && !shown[i];
      ev = 2'b00;
      if (entering) begin
        shown[i] = 1'b1;
        ev = mq[i][0].clip;
      end
      if (clip_clear) begin
        mflag[i] = ev;
        mcnt[i]  = (ev != 2'b00) ? 64'sd1 : 64'sd0;
      end else if (ev != 2'b00) begin
        mflag[i] = mflag[i] | ev;
        if (mcnt[i] < cmax_of(i)) mcnt[i] = mcnt[i] + 64'sd1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit evis, erdy;
    for (int i = 0; i < NI; i++) begin
      evis = (mq[i].size() > 0) && (mq[i][0].acc + 1 < edge_cnt);
      erdy = out_ready || (mq[i].size() < 2);
      check($sformatf("out_valid[%0d]", i), 64'(dv[i]), 64'(evis));
      check($sformatf("in_ready[%0d]", i), 64'(dr[i]), 64'(erdy));
      check($sformatf("clip_flag[%0d]", i), 64'(dflag[i]), 64'(mflag[i]));
      check($sformatf("clip_count[%0d]", i), 64'(dcnt[i]), 64'(mcnt[i]));
      if (evis) check($sformatf("out_data[%0d]", i), dd[i], mq[i][0].data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat with out_ready high; returns in the cycle it is visible.
  task automatic send(input logic [31:0] s0, input logic [31:0] s1);
    cyc();
    in_valid = 1'b1;
    src0 = s0;
    src1 = s1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_not_1", 64'(dv[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_2", 64'(dv), 64'hF);
  endtask

  task automatic random_run(input int target);
    int budget;
    budget = 0;
    while (n_acc < target && budget < 20000) begin
      cyc();
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 1) != 0);
      clip_clear = ($urandom_range(0, 39) == 0);
      src0 = $urandom;
      src1 = $urandom;
      budget++;
    end
    check("random_budget", 64'(n_acc >= target), 64'd1);
  endtask

  initial begin
    int waitc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clip_clear = 1'b0;
    src0 = 32'd0; src1 = 32'd0;
    repeat (3) cyc();
    rst_n = 1'b1;

    send(32'h0000_0800, 32'h0000_07FF);
    check("A_sext", dd[0], 64'h0000_0000_07FF_F800);
    check("A_noclip", 64'(dflag[0]), 64'd0);
    check("B_msb", dd[1], 64'h0000_0000_7FF0_8000);

    cyc(); clip_clear = 1'b1;
    cyc(); clip_clear = 1'b0;
    send(32'h0000_0900, 32'h0000_0000);
    check("C_satpos", dd[2], 64'h0000_0000_0000_07FF);
    send(32'h0000_F000, 32'h0000_0000);
    check("C_satneg", dd[2], 64'h0000_0000_0000_0800);
    check("C_count2", 64'(dcnt[2]), 64'd2);
    check("C_flag", 64'(dflag[2]), 64'd1);
    send(32'h0000_7FF8, 32'h0000_FFF8);
    check("D_round", dd[3], RND ? 64'h0000_0000_0000_07FF : 64'h0000_0000_00FF_F7FF);
    check("D_flag", 64'(dflag[3]), RND ? 64'd1 : 64'd0);

    random_run(500);

    // Fill both stages, then reset asynchronously between clock edges.
    cyc(); in_valid = 1'b1; out_ready = 1'b0; clip_clear = 1'b0;
    repeat (3) cyc();
    check("pre_reset_valid", 64'(dv), 64'hF);
    check("pre_reset_full", 64'(dr), 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(dv), 64'h0);
    check("reset_out_data_a", dd[0], 64'd0);
    check("reset_clip_count_c", 64'(dcnt[2]), 64'd0);
    in_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;

    random_run(1000);

    cyc(); in_valid = 1'b0; out_ready = 1'b1; clip_clear = 1'b0;
    waitc = 0;
    while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0 && waitc < 20) begin
      cyc();
      waitc++;
    end
    for (int i = 0; i < NI; i++) check($sformatf("drain[%0d]", i), 64'(mq[i].size()), 64'd0);
    @(negedge clk);
    check("idle_valid", 64'(dv), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
